tone_decoder: RTL and testbench
===============================

Name: tone_decoder

Overview:
- Receive-side counterpart to the piano tone generator: measures the period of an incoming square-wave tone and identifies it as C4, D4, E4, F4, G4 or none.
- Output uses the same one-hot note encoding as the piano switch inputs, so it can drive the existing seven-segment display module directly.
- Used for loopback self-test of the speaker output and for decoding an external tone line.

Parameters:
- CLK_MHZ, 100, system clock in MHz.
- W, 20, period counter width in bits.
- HALF_C4, 1911, C4 half-period in us (same for each note below).
- HALF_D4, 1703, D4 half-period in us.
- HALF_E4, 1517, E4 half-period in us.
- HALF_F4, 1432, F4 half-period in us.
- HALF_G4, 1276, G4 half-period in us.
- TOL, 4000, match tolerance in clock cycles (inclusive).
- LOCK_CNT, 3, consecutive identical classifications needed to change the reported note (1..7).
- TIMEOUT, 1000000, cycles without a rising edge before the tone is declared lost; must be < 2^W.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tone_in  input  1  asynchronous square-wave tone input
- note  output  5  one-hot note: bit0 = C4 … bit4 = G4; 0 = none
- note_code  output  3  0 = none, 1 = C4 … 5 = G4
- note_valid  output  1  high while note is non-zero
- period  output  W  last measured full period in clk cycles
- period_valid  output  1  one-cycle pulse when period updates

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All outputs and internal state are 0 in reset.
- Input conditioning:
  - tone_in passes through a 2-flop synchronizer, then a registered copy.
  - Rising edge is detected when synced = 1 and the delayed copy = 0. The edge pulse occurs 3 clk after the tone_in transition.
- Nominal full period for note X: NOM_X = 2*(CLK_MHZ*HALF_X + 1) cycles, computed at elaboration in W bits.
- FSM, IDLE:
  - cnt is held at 0.
  - On a rising edge: cnt <= 0, go to MEAS. No period is reported for this first edge.
- FSM, MEAS:
  - Without an edge: cnt <= cnt + 1.
  - On an edge:
    - period <= cnt + 1 (exact cycle distance between edges).
    - period_valid pulses for 1 cycle, the cycle after the edge.
    - cnt <= 0; stay in MEAS.
  - Timeout: if cnt == TIMEOUT-1 and there is no edge this cycle:
    - Go to IDLE next cycle.
    - note, note_code, note_valid and the candidate counter clear in that same cycle.
    - period holds its last value.
  - An edge and the timeout condition in the same cycle: the edge wins.
- Classification (on each new period):
  - cls = the lowest code X with |period - NOM_X| <= TOL, else 0. Absolute difference uses W+1-bit signed arithmetic.
  - If period matches two windows, the lower code wins.
- Lock logic (registered candidate cand[2:0] and count ccnt[2:0]):
  - If cls == note_code: ccnt <= 0.
  - Else if cls == cand: ccnt <= ccnt + 1. When ccnt + 1 == LOCK_CNT, set note_code <= cls and ccnt <= 0.
  - Else: cand <= cls, ccnt <= 1. If LOCK_CNT == 1, update note_code immediately.
- Note outputs update in the same cycle as period_valid.
  - note is the one-hot decode of note_code.
  - note_valid = |note.
- An out-of-tolerance tone counts as candidate 0, so a persistent off-pitch tone releases the note after LOCK_CNT periods.
- Reset mid-measurement aborts immediately. Post-reset, the first edge only arms MEAS.

Test Plan:
- Bench parameters: CLK_MHZ=1, TOL=40, LOCK_CNT=3, TIMEOUT=8000.
- Reset, tone_in held 0 for 10000 cycles -> all outputs 0, no period_valid pulse.
- Square wave with 1912-cycle half-period (C4, 3824 period) for 6 edges:
  - period_valid pulses 5 times, period = 3824 each.
  - note = 00001 and note_code = 1 on the 3rd pulse (4th edge), not earlier.
- Locked C4, then switch to a 1277-cycle half-period (G4, 2554) -> note remains 00001 for 2 G4 periods, becomes 10000 on the 3rd G4 period.
- Locked E4, then tone_in stuck high -> note clears exactly TIMEOUT cycles after the last rising edge; period holds 3036.
- Period 3824+40 = 3864 -> classified C4. Period 3865 -> cls = 0; after 3 such periods, note returns to 0.
- Assert rst_n low mid-period while locked on D4 -> outputs 0 asynchronously. After release, the first edge reports nothing; lock is reacquired after 3 more periods.

Source files
------------

// File: rtl/tone_decoder.sv
// Measures the period of a square-wave tone and reports which of C4..G4 it is,
// with a lock filter so a note only changes after repeated agreeing periods.
module tone_decoder #(
    parameter int CLK_MHZ  = 100,
    parameter int W        = 20,
    parameter int HALF_C4  = 1911,
    parameter int HALF_D4  = 1703,
    parameter int HALF_E4  = 1517,
    parameter int HALF_F4  = 1432,
    parameter int HALF_G4  = 1276,
    parameter int TOL      = 4000,
    parameter int LOCK_CNT = 3,
    parameter int TIMEOUT  = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tone_in,
    output logic [4:0]   note,
    output logic [2:0]   note_code,
    output logic         note_valid,
    output logic [W-1:0] period,
    output logic         period_valid
);

    localparam logic [W-1:0]        NOM_C4  = W'(2 * (CLK_MHZ * HALF_C4 + 1));
    localparam logic [W-1:0]        NOM_D4  = W'(2 * (CLK_MHZ * HALF_D4 + 1));
    localparam logic [W-1:0]        NOM_E4  = W'(2 * (CLK_MHZ * HALF_E4 + 1));
    localparam logic [W-1:0]        NOM_F4  = W'(2 * (CLK_MHZ * HALF_F4 + 1));
    localparam logic [W-1:0]        NOM_G4  = W'(2 * (CLK_MHZ * HALF_G4 + 1));
    localparam logic [W-1:0]        TO_LAST = W'(TIMEOUT - 1);
    localparam logic signed [W:0]   TOL_S   = (W+1)'(TOL);
    localparam logic [2:0]          LOCK_N  = 3'(LOCK_CNT);

    typedef enum logic {
        S_IDLE,
        S_MEAS
    } state_t;

    function automatic logic in_window(input logic [W-1:0] p, input logic [W-1:0] nom);
        logic signed [W:0] d;
        d = $signed({1'b0, p}) - $signed({1'b0, nom});
        if (d[W]) d = -d;
        return (d <= TOL_S);
    endfunction

    // Lower codes are tested first so overlapping windows resolve to the lower note.
    function automatic logic [2:0] classify(input logic [W-1:0] p);
        if (in_window(p, NOM_C4)) return 3'd1;
        if (in_window(p, NOM_D4)) return 3'd2;
        if (in_window(p, NOM_E4)) return 3'd3;
        if (in_window(p, NOM_F4)) return 3'd4;
        if (in_window(p, NOM_G4)) return 3'd5;
        return 3'd0;
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_sync_p0;
    logic           r_sync_p1;
    logic           r_dly_p2;
    logic           w_edge;
    logic           w_meas_edge;
    logic           w_timeout;
    logic [W-1:0]   r_cnt;
    logic [W-1:0]   w_meas;
    logic [2:0]     w_cls;
    logic [W-1:0]   r_period_p3;
    logic           r_vld_p3;
    logic [2:0]     r_code;
    logic [2:0]     r_cand;
    logic [2:0]     r_ccnt;
    logic [2:0]     w_ccnt_inc;
    logic [4:0]     w_note;

    // stage p0..p2: two-flop synchronizer plus delayed copy for rising-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
            r_dly_p2  <= 1'b0;
        end else begin
            r_sync_p0 <= tone_in;
            r_sync_p1 <= r_sync_p0;
            r_dly_p2  <= r_sync_p1;
        end
    end

    assign w_edge     = r_sync_p1 & ~r_dly_p2;
    assign w_meas     = r_cnt + W'(1);
    assign w_cls      = classify(w_meas);
    assign w_ccnt_inc = r_ccnt + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_meas_edge = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge) w_state_nxt = S_MEAS;
            end
            S_MEAS: begin
                if (w_edge) begin
                    w_meas_edge = 1'b1;
                end else if (r_cnt == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_state == S_MEAS && !w_edge && !w_timeout)
            r_cnt <= r_cnt + W'(1);
        else
            r_cnt <= '0;
    end

    // stage p3: registered period and note update, both visible the cycle after the edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_p3 <= '0;
            r_vld_p3    <= 1'b0;
        end else begin
            r_vld_p3 <= w_meas_edge;
            if (w_meas_edge) r_period_p3 <= w_meas;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code <= 3'd0;
            r_cand <= 3'd0;
            r_ccnt <= 3'd0;
        end else if (w_timeout) begin
            r_code <= 3'd0;
            r_cand <= 3'd0;
            r_ccnt <= 3'd0;
        end else if (w_meas_edge) begin
            if (w_cls == r_code) begin
                r_ccnt <= 3'd0;
            end else if (w_cls == r_cand) begin
                if (w_ccnt_inc == LOCK_N) begin
                    r_code <= w_cls;
                    r_ccnt <= 3'd0;
                end else begin
                    r_ccnt <= w_ccnt_inc;
                end
            end else begin
                r_cand <= w_cls;
                r_ccnt <= 3'd1;
                if (LOCK_N == 3'd1) r_code <= w_cls;
            end
        end
    end

    always_comb begin
        w_note = 5'b00000;
        case (r_code)
            3'd1:    w_note = 5'b00001;
            3'd2:    w_note = 5'b00010;
            3'd3:    w_note = 5'b00100;
            3'd4:    w_note = 5'b01000;
            3'd5:    w_note = 5'b10000;
            default: w_note = 5'b00000;
        endcase
    end

    assign note         = w_note;
    assign note_code    = r_code;
    assign note_valid   = |w_note;
    assign period       = r_period_p3;
    assign period_valid = r_vld_p3;

endmodule

// File: tb/tb_tone_decoder.sv
// Scoreboard bench for tone_decoder: expected period/note pairs are queued per
// rising edge and checked by a monitor whenever period_valid pulses.
module tb_tone_decoder;

    localparam int W       = 20;
    localparam int TIMEOUT = 8000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tone_in = 1'b0;
    logic [4:0]   note;
    logic [2:0]   note_code;
    logic         note_valid;
    logic [W-1:0] period;
    logic         period_valid;

    always #5 clk = ~clk;

    tone_decoder #(
        .CLK_MHZ(1), .W(W), .TOL(40), .LOCK_CNT(3), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tone_in(tone_in),
        .note(note), .note_code(note_code), .note_valid(note_valid),
        .period(period), .period_valid(period_valid)
    );

    typedef struct {
        int per;
        int code;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_pv_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] onehot(input int code);
        if (code == 0) return 5'd0;
        return 5'(1 << (code - 1));
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic exp_pv(input int p, input int c);
        exp_t e;
        e.per  = p;
        e.code = c;
        q.push_back(e);
    endtask

    // One full tone cycle of len clocks starting with a rising edge.
    task automatic tcyc(input int len);
        tone_in = 1'b1;
        repeat (len / 2) @(negedge clk);
        tone_in = 1'b0;
        repeat (len - len / 2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_note"}, int'(note), 0);
        check({tag, "_code"}, int'(note_code), 0);
        check({tag, "_nvalid"}, int'(note_valid), 0);
        check({tag, "_period"}, int'(period), 0);
        check({tag, "_pvalid"}, int'(period_valid), 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (period_valid) begin
                last_pv_cyc = cyc;
                if (q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_pv: got pulse with period %0d, required none", period);
                end else begin
                    e = q.pop_front();
                    check("period", int'(period), e.per);
                    check("note_code", int'(note_code), e.code);
                    check("note", int'(note), int'(onehot(e.code)));
                    check("note_valid", int'(note_valid), int'(e.code != 0));
                end
            end
        end
    end

    initial begin
        int k;
        int t0;
        rst_n   = 1'b0;
        tone_in = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (10000) @(negedge clk);
        check_zero("idle");

        // C4 lock: 6 edges, 5 reports, lock on the 3rd report
        tcyc(3824);
        exp_pv(3824, 0); tcyc(3824);
        exp_pv(3824, 0); tcyc(3824);
        exp_pv(3824, 1); tcyc(3824);
        exp_pv(3824, 1); tcyc(3824);
        // switch to G4: note holds C4 for two G4 periods
        exp_pv(3824, 1); tcyc(2554);
        exp_pv(2554, 1); tcyc(2554);
        exp_pv(2554, 1); tcyc(2554);
        exp_pv(2554, 5); tcyc(3864);
        // 3864 is inside the C4 window, 3865 is not: release after three 3865s
        exp_pv(3864, 5); tcyc(3865);
        exp_pv(3865, 5); tcyc(3865);
        exp_pv(3865, 5); tcyc(3865);
        exp_pv(3865, 0); tcyc(3036);
        // E4 lock, then tone stuck high
        exp_pv(3036, 0); tcyc(3036);
        exp_pv(3036, 0); tcyc(3036);
        exp_pv(3036, 3);
        tone_in = 1'b1;
        k = 0;
        while (q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("e4_pending", q.size(), 0);
        t0 = last_pv_cyc;
        k = 0;
        while (note_valid && k < TIMEOUT + 100) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", cyc - t0, TIMEOUT);
        check("timeout_code", int'(note_code), 0);
        check("timeout_period", int'(period), 3036);

        // D4 lock, then asynchronous reset mid-period
        tone_in = 1'b0;
        repeat (100) @(negedge clk);
        tcyc(3408);
        exp_pv(3408, 0); tcyc(3408);
        exp_pv(3408, 0); tcyc(3408);
        exp_pv(3408, 2);
        tone_in = 1'b1;
        repeat (500) @(negedge clk);
        check("d4_pending", q.size(), 0);
        check("d4_code", int'(note_code), 2);
        check("d4_note", int'(note), 2);
        #3 rst_n = 1'b0;
        #1 check_zero("async_rst");
        tone_in = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        tcyc(3408);
        exp_pv(3408, 0); tcyc(3408);
        exp_pv(3408, 0); tcyc(3408);
        exp_pv(3408, 2);
        tone_in = 1'b1;
        repeat (10) @(negedge clk);
        check("relock_pending", q.size(), 0);
        check("relock_code", int'(note_code), 2);
        check("relock_note", int'(note), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
